// File: rtl/enemy_ai_if.sv
// Bundle of game-controller inputs and enemy command outputs for the AI scheduler.
// The master is the game/controller side; the slave is the scheduler.
interface enemy_ai_if;
    logic               i_enable;
    logic signed [10:0] i_player_x;
    logic signed [9:0]  i_player_y;
    logic signed [10:0] i_enemy_x;
    logic signed [9:0]  i_enemy_y;
    logic signed [10:0] i_goodbullet_x;
    logic               i_goodbullet_isE;
    logic               i_badbullet_isE;
    logic               o_right;
    logic               o_left;
    logic               o_jump;
    logic               o_squat;
    logic               o_attack;
    logic               o_defend;
    logic [2:0]         o_ai_state;

    modport master (
        output i_enable, i_player_x, i_player_y, i_enemy_x, i_enemy_y,
               i_goodbullet_x, i_goodbullet_isE, i_badbullet_isE,
        input  o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_ai_state
    );

    modport slave (
        input  i_enable, i_player_x, i_player_y, i_enemy_x, i_enemy_y,
               i_goodbullet_x, i_goodbullet_isE, i_badbullet_isE,
        output o_right, o_left, o_jump, o_squat, o_attack, o_defend, o_ai_state
    );
endinterface

// File: rtl/enemy_ai_scheduler.sv
// Enemy action scheduler: one decision per TICK_DIV cycles, commands registered 1 cycle after tick.
// No backpressure; optional shield in EVADE enabled by macro ENEMY_AI_SHIELD_EN.
module enemy_ai_scheduler #(
    parameter int          TICK_DIV      = 64,
    parameter int          NEAR_DIST     = 128,
    parameter int          FAR_DIST      = 320,
    parameter int          EVADE_DIST    = 96,
    parameter int          FIRE_COOLDOWN = 4,
    parameter int          X_MIN         = 0,
    parameter int          X_MAX         = 600,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic       clk,
    input logic       rst,
    enemy_ai_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        APPROACH = 3'd2,
        RETREAT  = 3'd3,
        EVADE    = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int CD_W  = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(FIRE_COOLDOWN);
    localparam logic [11:0] NEAR_12  = 12'(NEAR_DIST);
    localparam logic [11:0] FAR_12   = 12'(FAR_DIST);
    localparam logic [11:0] EVADE_12 = 12'(EVADE_DIST);
    localparam logic [11:0] XMIN_12  = 12'(X_MIN);
    localparam logic [11:0] XMAX_12  = 12'(X_MAX);

`ifdef ENEMY_AI_SHIELD_EN
    localparam logic SHIELD = 1'b1;
`else
    localparam logic SHIELD = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [CD_W-1:0]  cooldown;
    logic [15:0]      lfsr;

    logic        tick;
    logic [11:0] ex, dx, bx, adist, bdist;
    logic        dx_pos, dx_neg, at_min, at_max;
    logic        mv_right, mv_left, fire, shield_up, lfsr_fb;
    state_t      nxt;

    assign tick    = (tick_cnt == CNT_LAST);
    assign ex      = {bus.i_enemy_x[10], bus.i_enemy_x};
    assign dx      = {bus.i_player_x[10], bus.i_player_x} - ex;
    assign bx      = {bus.i_goodbullet_x[10], bus.i_goodbullet_x} - ex;
    assign adist   = dx[11] ? (12'd0 - dx) : dx;
    assign bdist   = bx[11] ? (12'd0 - bx) : bx;
    assign dx_neg  = dx[11];
    assign dx_pos  = !dx[11] && (dx != 12'd0);
    assign at_min  = $signed(ex) <= $signed(XMIN_12);
    assign at_max  = $signed(ex) >= $signed(XMAX_12);
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        nxt = HOLD;
        if (bus.i_goodbullet_isE && (bdist < EVADE_12)) nxt = EVADE;
        else if (adist > FAR_12)                        nxt = APPROACH;
        else if (adist < NEAR_12)                       nxt = RETREAT;
    end

    // Direction intent first, then arena walls veto the move toward them.
    always_comb begin
        mv_right = 1'b0;
        mv_left  = 1'b0;
        if (nxt == APPROACH) begin
            mv_right = dx_pos;
            mv_left  = dx_neg;
        end else if (nxt == RETREAT) begin
            mv_right = dx_neg;
            mv_left  = !dx_neg;
        end
        if (at_min) mv_left  = 1'b0;
        if (at_max) mv_right = 1'b0;
    end

    assign fire      = (cooldown == '0) && !bus.i_badbullet_isE && (nxt != EVADE);
    assign shield_up = SHIELD && lfsr[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            cooldown     <= '0;
            lfsr         <= LFSR_SEED;
            bus.o_right  <= 1'b0;
            bus.o_left   <= 1'b0;
            bus.o_jump   <= 1'b0;
            bus.o_squat  <= 1'b0;
            bus.o_attack <= 1'b0;
            bus.o_defend <= 1'b0;
        end else if (!bus.i_enable) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            cooldown     <= '0;
            bus.o_right  <= 1'b0;
            bus.o_left   <= 1'b0;
            bus.o_jump   <= 1'b0;
            bus.o_squat  <= 1'b0;
            bus.o_attack <= 1'b0;
            bus.o_defend <= 1'b0;
        end else begin
            bus.o_attack <= 1'b0;
            if (tick) begin
                tick_cnt     <= '0;
                lfsr         <= {lfsr[14:0], lfsr_fb};
                state        <= nxt;
                bus.o_right  <= mv_right;
                bus.o_left   <= mv_left;
                bus.o_jump   <= (nxt == EVADE) && !shield_up && lfsr[0];
                bus.o_squat  <= (nxt == EVADE) && !shield_up && !lfsr[0];
                bus.o_defend <= (nxt == EVADE) && shield_up;
                bus.o_attack <= fire;
                if (fire)                cooldown <= CD_LOAD;
                else if (cooldown != '0) cooldown <= cooldown - 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign bus.o_ai_state = state;
endmodule
